// File: rtl/quad_encoder_gen_pkg.sv
// Shared encodings for the quadrature generator and its reader.
// FSM states, direction codes and the {B,A} Gray sequence.
package quad_encoder_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;

  // Reader-side direction report
  localparam logic [1:0] RD_NONE = 2'b00;
  localparam logic [1:0] RD_CW   = 2'b01;
  localparam logic [1:0] RD_CCW  = 2'b10;

  // {B,A} phases in CW order
  localparam logic [1:0] QS0 = 2'b00;
  localparam logic [1:0] QS1 = 2'b01;
  localparam logic [1:0] QS2 = 2'b11;
  localparam logic [1:0] QS3 = 2'b10;

  function automatic logic [1:0] quad_next(
    input logic [1:0] ba,
    input logic       dir
  );
    logic [1:0] nx;
    nx = ba;
    unique case (ba)
      QS0: nx = (dir == DIR_CW) ? QS1 : QS3;
      QS1: nx = (dir == DIR_CW) ? QS2 : QS0;
      QS2: nx = (dir == DIR_CW) ? QS3 : QS1;
      QS3: nx = (dir == DIR_CW) ? QS0 : QS2;
      default: nx = QS0;
    endcase
    return nx;
  endfunction

  function automatic logic [1:0] quad_decode(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    logic [1:0] rd;
    rd = RD_NONE;
    if (cur == quad_next(prev, DIR_CW))
      rd = RD_CW;
    else if (cur == quad_next(prev, DIR_CCW))
      rd = RD_CCW;
    return rd;
  endfunction

endpackage

// File: rtl/quad_encoder_gen_step_timer.sv
// Step-period divider: ticks once every period clocks while enabled.
// A period of zero is treated as one.
module step_timer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] per_q;

  assign tick = en && (cnt == per_q - ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      per_q <= '0;
    end else if (load) begin
      cnt   <= '0;
      per_q <= (period == '0) ? ONE : period;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature A/B generator: emits a commanded number of steps
// at a fixed period, tracking a wrapping signed position.
module quad_encoder_gen
  import quad_encoder_gen_pkg::*;
#(
  parameter int STEP_W = 16,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0]  cmd_period,
  input  logic              abort,
  output logic              A,
  output logic              B,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] position
);

  localparam logic [STEP_W-1:0] S_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

  state_t            state, state_n;
  logic [STEP_W-1:0] rem, rem_n;
  logic [STEP_W-1:0] pos, pos_n;
  logic [1:0]        ba, ba_n;
  logic              dir_q, dir_n;
  logic              done_n;
  logic              load;
  logic              tick;

  step_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (state == RUN),
    .load   (load),
    .period (cmd_period),
    .tick   (tick)
  );

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RUN);
  assign A         = ba[0];
  assign B         = ba[1];
  assign position  = pos;

  always_comb begin
    state_n = state;
    rem_n   = rem;
    pos_n   = pos;
    ba_n    = ba;
    dir_n   = dir_q;
    done_n  = 1'b0;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          load  = 1'b1;
          dir_n = cmd_dir;
          rem_n = cmd_steps;
          if (cmd_steps == '0)
            done_n = 1'b1;
          else
            state_n = RUN;
        end
      end
      RUN: begin
        // abort wins over a step due on the same edge
        if (abort) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else if (tick) begin
          ba_n  = quad_next(ba, dir_q);
          pos_n = (dir_q == DIR_CW) ? pos + S_ONE : pos - S_ONE;
          rem_n = rem - S_ONE;
          if (rem == S_ONE) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      pos   <= '0;
      ba    <= QS0;
      dir_q <= DIR_CW;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      pos   <= pos_n;
      ba    <= ba_n;
      dir_q <= dir_n;
      done  <= done_n;
    end
  end

endmodule
